// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state encoding and reset configuration for the sequence detector
// Contents: seq_det_state_t (UNCFG/FILL/HUNT/MATCH), SEQ_DET_RST_PAT, SEQ_DET_RST_LEN.
package seq_det_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'b00,
        FILL  = 2'b01,
        HUNT  = 2'b10,
        MATCH = 2'b11
    } seq_det_state_t;

    localparam logic [31:0] SEQ_DET_RST_PAT = 32'b1011;
    localparam int          SEQ_DET_RST_LEN = 4;

endpackage

// File: rtl/seq_det_history.sv
// rtl/seq_det_history.sv - serial history shift register, fill counter and pattern compare
// Ports: clock, reset (async, active-high), clear (restart), shift (accepted bit), bit_in,
//        pat/len/ovl (active configuration), hit (post-shift match), full (post-shift fill >= len).
module seq_det_history
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift,
    input  logic               bit_in,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    input  logic               ovl,
    output logic               hit,
    output logic               full
);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_next;

    // hit/full describe the state after the bit currently offered is shifted in,
    // so the FSM can move to MATCH on the same edge that accepts the bit.
    always_comb begin
        hist_next = {hist[MAX_LEN-2:0], bit_in};
        fill_next = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
        mask      = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        full = (len != '0) && (fill_next >= len);
        hit  = full && ((hist_next & mask) == (pat & mask));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= hist_next;
            // Non-overlapping mode forgets every bit consumed by a match.
            fill <= (hit && !ovl) ? '0 : fill_next;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-configurable serial pattern detector (Moore output)
// Ports: clock, reset (async, active-high), sequence_in/in_valid (serial bit stream),
//        cfg_load/cfg_pattern/cfg_len/cfg_overlap (configuration, restarts detection),
//        detector_out (MATCH decode), state_out (FSM state),
//        match_count (saturating hit counter, only when SEQ_DET_MATCH_COUNT_EN is defined).
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         sequence_in,
    input  logic                         in_valid,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    output logic                         detector_out,
    output logic [1:0]                   state_out
`ifdef SEQ_DET_MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0]             match_count
`endif
);

    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int RST_LEN = (SEQ_DET_RST_LEN > MAX_LEN) ? MAX_LEN : SEQ_DET_RST_LEN;

    seq_det_state_t     state;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic [LEN_W-1:0]   cfg_len_eff;
    logic               accept;
    logic               hit;
    logic               full;

    assign cfg_len_eff = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

    // A bit landing in the same cycle as cfg_load is dropped; len 0 disables input.
    assign accept = in_valid && !cfg_load && (len != '0);

    seq_det_history #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_history (
        .clock  (clock),
        .reset  (reset),
        .clear  (cfg_load),
        .shift  (accept),
        .bit_in (sequence_in),
        .pat    (pat),
        .len    (len),
        .ovl    (ovl),
        .hit    (hit),
        .full   (full)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pat   <= MAX_LEN'(SEQ_DET_RST_PAT);
            len   <= LEN_W'(RST_LEN);
            ovl   <= 1'b1;
            state <= FILL;
        end else if (cfg_load) begin
            pat   <= cfg_pattern;
            len   <= cfg_len_eff;
            ovl   <= cfg_overlap;
            state <= (cfg_len_eff == '0) ? UNCFG : FILL;
        end else if (len == '0) begin
            state <= UNCFG;
        end else if (accept) begin
            if (hit) begin
                state <= MATCH;
            end else if (full) begin
                state <= HUNT;
            end else begin
                state <= FILL;
            end
        end
    end

    assign state_out    = state;
    assign detector_out = (state == MATCH);

`ifdef SEQ_DET_MATCH_COUNT_EN
    // Every accepted hit is an entry into MATCH, including MATCH -> MATCH in overlap mode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            match_count <= '0;
        end else if (cfg_load) begin
            match_count <= '0;
        end else if (accept && hit && (match_count != {CNT_W{1'b1}})) begin
            match_count <= match_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed self-checking bench for seq_detector_param
module tb_seq_detector_param;

    logic       clock;
    logic       reset;
    logic       sequence_in;
    logic       in_valid;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       detector_out;
    logic [1:0] state_out;
`ifdef SEQ_DET_MATCH_COUNT_EN
    logic [1:0] match_count;
`endif

    int checks = 0;
    int errors = 0;

    logic       b7 [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] s7 [7] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11};
    logic       ba5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    seq_detector_param #(
        .MAX_LEN (8),
        .CNT_W   (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .in_valid     (in_valid),
        .cfg_load     (cfg_load),
        .cfg_pattern  (cfg_pattern),
        .cfg_len      (cfg_len),
        .cfg_overlap  (cfg_overlap),
        .detector_out (detector_out),
        .state_out    (state_out)
`ifdef SEQ_DET_MATCH_COUNT_EN
        ,
        .match_count  (match_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // State and the Moore output are checked together; detector_out must equal the MATCH decode.
    task automatic check_state(input string tag, input logic [1:0] exp_state);
        check({tag, "_state"}, 32'(state_out), 32'(exp_state));
        check({tag, "_det"}, 32'(detector_out), 32'(exp_state == 2'b11));
    endtask

    task automatic check_count(input string tag, input logic [1:0] exp_count);
`ifdef SEQ_DET_MATCH_COUNT_EN
        check(tag, 32'(match_count), 32'(exp_count));
`else
        if (exp_count === 2'bxx) $display("unused %s", tag);
`endif
    endtask

    task automatic send(input logic b);
        sequence_in = b;
        in_valid    = 1'b1;
        @(posedge clock);
        #1;
        in_valid    = 1'b0;
    endtask

    task automatic idle();
        sequence_in = ~sequence_in;
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_load    = 1'b1;
        @(posedge clock);
        #1;
        cfg_load    = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        sequence_in = 1'b0;
        in_valid    = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = 8'h00;
        cfg_len     = 4'd0;
        cfg_overlap = 1'b0;
        #12;
        reset = 1'b0;

        // Reset values
        check_state("rst", 2'b01);
        check_count("rst_count", 2'd0);

        // Default overlapping 1011 detector: 1,0,1,1,0,1,1
        for (int i = 0; i < 7; i++) begin
            send(b7[i]);
            check_state($sformatf("dflt_bit%0d", i + 1), s7[i]);
        end
        check_count("dflt_count", 2'd2);

        // Oversized cfg_len clamps to 8: eight ones match only after the eighth
        load(8'hFF, 4'd15, 1'b1);
        check_state("clamp_load", 2'b01);
        check_count("clamp_load_count", 2'd0);
        for (int i = 0; i < 7; i++) begin
            send(1'b1);
            check_state($sformatf("clamp_bit%0d", i + 1), 2'b01);
        end
        send(1'b1);
        check_state("clamp_bit8", 2'b11);

        // Non-overlap: pattern 11, bits 1,1,1,1 -> matches after bits 2 and 4
        load(8'h03, 4'd2, 1'b0);
        send(1'b1); check_state("novl_bit1", 2'b01);
        send(1'b1); check_state("novl_bit2", 2'b11);
        send(1'b1); check_state("novl_bit3", 2'b01);
        send(1'b1); check_state("novl_bit4", 2'b11);
        check_count("novl_count", 2'd2);

        // Overlap: same stimulus -> matches after bits 2, 3 and 4
        load(8'h03, 4'd2, 1'b1);
        send(1'b1); check_state("ovl_bit1", 2'b01);
        send(1'b1); check_state("ovl_bit2", 2'b11);
        send(1'b1); check_state("ovl_bit3", 2'b11);
        send(1'b1); check_state("ovl_bit4", 2'b11);
        check_count("ovl_count", 2'd3);
        // Counter saturation at 2^2-1
        send(1'b1); check_state("sat_bit5", 2'b11);
        check_count("sat_count", 2'd3);

        // Valid gaps: 1,0, five idle cycles, 1,1; MATCH holds until the next accepted bit
        load(8'h0B, 4'd4, 1'b1);
        send(1'b1);
        send(1'b0);
        for (int i = 0; i < 5; i++) begin
            idle();
            check_state($sformatf("gap_idle%0d", i), 2'b01);
        end
        send(1'b1); check_state("gap_bit3", 2'b01);
        send(1'b1); check_state("gap_bit4", 2'b11);
        for (int i = 0; i < 3; i++) begin
            idle();
            check_state($sformatf("gap_hold%0d", i), 2'b11);
        end
        send(1'b0); check_state("gap_bit5", 2'b10);

        // cfg_load collides with the final 1 of 1011: bit discarded, new config active
        load(8'h0B, 4'd4, 1'b1);
        send(1'b1);
        send(1'b0);
        send(1'b1);
        sequence_in = 1'b1;
        in_valid    = 1'b1;
        load(8'hA5, 4'd8, 1'b1);
        in_valid    = 1'b0;
        check_state("coll_load", 2'b01);
        check_count("coll_count0", 2'd0);
        for (int i = 0; i < 8; i++) begin
            send(ba5[i]);
            check_state($sformatf("a5_bit%0d", i + 1), (i == 7) ? 2'b11 : 2'b01);
        end
        check_count("a5_count", 2'd1);

        // len 0 disables detection
        load(8'h00, 4'd0, 1'b1);
        check_state("len0_load", 2'b00);
        for (int i = 0; i < 20; i++) begin
            send(1'($urandom_range(0, 1)));
            check_state($sformatf("len0_bit%0d", i), 2'b00);
        end
        check_count("len0_count", 2'd0);

        // Reset mid-pattern restores defaults and abandons the partial match
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        check_state("pre_rst_match", 2'b11);
        send(1'b0); send(1'b1);
        check_state("pre_rst_hunt", 2'b10);
        #2;
        reset = 1'b1;
        #1;
        check_state("in_rst", 2'b01);
        check_count("in_rst_count", 2'd0);
        #2;
        reset = 1'b0;
        #1;
        check_state("post_rst", 2'b01);
        send(1'b1); check_state("post_rst_bit1", 2'b01);
        send(1'b0); check_state("post_rst_bit2", 2'b01);
        send(1'b1); check_state("post_rst_bit3", 2'b01);
        send(1'b1); check_state("post_rst_bit4", 2'b11);
        check_count("post_rst_count", 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
